// File: rtl/icache_pkg.sv
// Shared definitions for the instruction-cache line-refill controller.
// Holds the refill FSM state type, default geometry constants and the
// burst-length encoding helper used by icache_refill_ctrl and its address generator.
package icache_pkg;

  typedef enum logic [1:0] {
    StIdle = 2'd0,
    StReq  = 2'd1,
    StFill = 2'd2,
    StDone = 2'd3
  } refill_state_e;

  localparam int unsigned LineWords = 8;
  localparam int unsigned OffW      = $clog2(LineWords);
  localparam int unsigned RamAw     = 11;
  localparam int unsigned PcW       = 32;

  // Memory bursts are encoded as length minus one.
  function automatic logic [7:0] mem_len_enc(input int unsigned words);
    return 8'(words - 1);
  endfunction

endpackage

// File: rtl/icache_refill_addr_gen.sv
// Address generator for a cache-line refill.
// Latches the line fields of the missing PC, produces the line-aligned memory
// burst address and the data-RAM write address {line, beat}, and flags the last beat.
// Optional macro ICACHE_REFILL_BYPASS_EN adds slot_hit_o (current beat is the
// critical word of the miss).
//
// Ports:
//   clk_i, rst_ni  clock, asynchronous active-low reset
//   latch_i        capture miss_pc_i and clear the beat counter
//   beat_i         a refill beat is written this cycle; advance the counter
//   miss_pc_i      byte address of the missing instruction
//   mem_addr_o     line-aligned burst byte address
//   fill_addr_o    data-RAM word address of the current beat
//   last_beat_o    current beat is the final word of the line
//   slot_hit_o     (bypass build) current beat is the requested word
module icache_refill_addr_gen
  import icache_pkg::*;
#(
  parameter int unsigned LINE_WORDS = LineWords,
  parameter int unsigned RAM_AW     = RamAw,
  parameter int unsigned PC_W       = PcW
) (
  input  logic              clk_i,
  input  logic              rst_ni,
  input  logic              latch_i,
  input  logic              beat_i,
  input  logic [PC_W-1:0]   miss_pc_i,
  output logic [PC_W-1:0]   mem_addr_o,
  output logic [RAM_AW-1:0] fill_addr_o,
  output logic              last_beat_o
`ifdef ICACHE_REFILL_BYPASS_EN
  ,
  output logic              slot_hit_o
`endif
);

  localparam int unsigned OFF_W = $clog2(LINE_WORDS);

  logic [RAM_AW-OFF_W-1:0] line_ram_q;
  logic [PC_W-OFF_W-3:0]   line_pc_q;
  logic [OFF_W-1:0]        cnt_q;

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      line_ram_q <= '0;
      line_pc_q  <= '0;
      cnt_q      <= '0;
    end else if (latch_i) begin
      line_ram_q <= miss_pc_i[RAM_AW+1:OFF_W+2];
      line_pc_q  <= miss_pc_i[PC_W-1:OFF_W+2];
      cnt_q      <= '0;
    end else if (beat_i) begin
      // Wraps at OFF_W bits; never consulted after the last beat.
      cnt_q <= cnt_q + OFF_W'(1);
    end
  end

  assign mem_addr_o  = {line_pc_q, {(OFF_W + 2){1'b0}}};
  assign fill_addr_o = {line_ram_q, cnt_q};
  assign last_beat_o = (cnt_q == OFF_W'(LINE_WORDS - 1));

`ifdef ICACHE_REFILL_BYPASS_EN
  logic [OFF_W-1:0] word_q;

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      word_q <= '0;
    end else if (latch_i) begin
      word_q <= miss_pc_i[OFF_W+1:2];
    end
  end

  assign slot_hit_o = (cnt_q == word_q);

  logic unused_pc_bits;
  assign unused_pc_bits = ^miss_pc_i[1:0];
`else
  logic unused_pc_bits;
  assign unused_pc_bits = ^miss_pc_i[OFF_W+1:0];
`endif

endmodule

// File: rtl/icache_refill_ctrl.sv
// Instruction-cache line-refill controller and data-RAM port arbiter.
// On a miss, issues one burst read for the line, writes each returned beat into
// the single-port data RAM, and pulses refill_done_o (with refill_error_o) when
// the whole line is in. Refill beats take the RAM port; fetch lookups get it
// otherwise and see fetch_stall_o when they lose.
// Optional macro ICACHE_REFILL_BYPASS_EN adds bypass_valid_o/bypass_data_o,
// which forward the requested word as it arrives.
//
// Ports:
//   clk_i, rst_i                          clock, asynchronous active-low reset
//   fetch_rd_i, fetch_addr_i              fetch lookup request / RAM word address
//   fetch_stall_o                         fetch lookup lost the RAM port this cycle
//   miss_i, miss_pc_i                     miss request (level) and missing byte address
//   refill_busy_o                         refill in progress
//   refill_done_o, refill_error_o         completion pulse and its error status
//   mem_rd_o, mem_addr_o, mem_len_o       burst read request
//   mem_accept_i                          burst request accepted
//   mem_valid_i, mem_data_i, mem_error_i  returned beat
//   ram_addr_o, ram_data_o, ram_wr_o      data RAM port
module icache_refill_ctrl
  import icache_pkg::*;
#(
  parameter int unsigned LINE_WORDS = LineWords,
  parameter int unsigned RAM_AW     = RamAw,
  parameter int unsigned PC_W       = PcW
) (
  input  logic              clk_i,
  input  logic              rst_i,
  input  logic              fetch_rd_i,
  input  logic [RAM_AW-1:0] fetch_addr_i,
  output logic              fetch_stall_o,
  input  logic              miss_i,
  input  logic [PC_W-1:0]   miss_pc_i,
  output logic              refill_busy_o,
  output logic              refill_done_o,
  output logic              refill_error_o,
  output logic              mem_rd_o,
  output logic [PC_W-1:0]   mem_addr_o,
  output logic [7:0]        mem_len_o,
  input  logic              mem_accept_i,
  input  logic              mem_valid_i,
  input  logic [31:0]       mem_data_i,
  input  logic              mem_error_i,
  output logic [RAM_AW-1:0] ram_addr_o,
  output logic [31:0]       ram_data_o,
  output logic              ram_wr_o
`ifdef ICACHE_REFILL_BYPASS_EN
  ,
  output logic              bypass_valid_o,
  output logic [31:0]       bypass_data_o
`endif
);

  refill_state_e     state_q;
  logic              mem_rd_q;
  logic              busy_q;
  logic              done_q;
  logic              error_q;
  logic              err_flag_q;
  logic [7:0]        mem_len_q;

  logic              latch;
  logic              beat;
  logic              last_beat;
  logic [RAM_AW-1:0] fill_addr;
`ifdef ICACHE_REFILL_BYPASS_EN
  logic              slot_hit;
`endif

  assign latch = (state_q == StIdle) && miss_i;
  assign beat  = (state_q == StFill) && mem_valid_i;

  icache_refill_addr_gen #(
    .LINE_WORDS (LINE_WORDS),
    .RAM_AW     (RAM_AW),
    .PC_W       (PC_W)
  ) u_addr_gen (
    .clk_i       (clk_i),
    .rst_ni      (rst_i),
    .latch_i     (latch),
    .beat_i      (beat),
    .miss_pc_i   (miss_pc_i),
    .mem_addr_o  (mem_addr_o),
    .fill_addr_o (fill_addr),
    .last_beat_o (last_beat)
`ifdef ICACHE_REFILL_BYPASS_EN
    ,
    .slot_hit_o  (slot_hit)
`endif
  );

  always_ff @(posedge clk_i or negedge rst_i) begin
    if (!rst_i) begin
      state_q    <= StIdle;
      mem_rd_q   <= 1'b0;
      busy_q     <= 1'b0;
      done_q     <= 1'b0;
      error_q    <= 1'b0;
      err_flag_q <= 1'b0;
      mem_len_q  <= '0;
    end else begin
      done_q  <= 1'b0;
      error_q <= 1'b0;
      unique case (state_q)
        StIdle: begin
          if (miss_i) begin
            state_q    <= StReq;
            mem_rd_q   <= 1'b1;
            busy_q     <= 1'b1;
            err_flag_q <= 1'b0;
            mem_len_q  <= mem_len_enc(LINE_WORDS);
          end
        end
        StReq: begin
          if (mem_accept_i) begin
            state_q  <= StFill;
            mem_rd_q <= 1'b0;
          end
        end
        StFill: begin
          if (mem_valid_i) begin
            err_flag_q <= err_flag_q | mem_error_i;
            if (last_beat) begin
              state_q <= StDone;
              done_q  <= 1'b1;
              // Fold in the final beat's error, which the flag has not seen yet.
              error_q <= err_flag_q | mem_error_i;
            end
          end
        end
        StDone: begin
          state_q <= StIdle;
          busy_q  <= 1'b0;
        end
        default: state_q <= StIdle;
      endcase
    end
  end

  assign mem_rd_o       = mem_rd_q;
  assign mem_len_o      = mem_len_q;
  assign refill_busy_o  = busy_q;
  assign refill_done_o  = done_q;
  assign refill_error_o = error_q;

  // Refill beats own the RAM port; every other cycle belongs to fetch.
  always_comb begin
    ram_wr_o      = beat;
    ram_addr_o    = fetch_addr_i;
    ram_data_o    = '0;
    fetch_stall_o = 1'b0;
    if (beat) begin
      ram_addr_o    = fill_addr;
      ram_data_o    = mem_data_i;
      fetch_stall_o = fetch_rd_i;
    end
  end

`ifdef ICACHE_REFILL_BYPASS_EN
  assign bypass_valid_o = beat && slot_hit;
  assign bypass_data_o  = bypass_valid_o ? mem_data_i : '0;
`endif

endmodule

// File: tb/tb_icache_refill_ctrl.sv
// Self-checking bench for icache_refill_ctrl (LINE_WORDS=8, RAM_AW=11, PC_W=32).
// Inputs change on the falling edge; outputs are checked 1 ns later.
module tb_icache_refill_ctrl;

  localparam int LW = 8;

  logic        clk;
  logic        rst_i;
  logic        fetch_rd_i;
  logic [10:0] fetch_addr_i;
  logic        fetch_stall_o;
  logic        miss_i;
  logic [31:0] miss_pc_i;
  logic        refill_busy_o;
  logic        refill_done_o;
  logic        refill_error_o;
  logic        mem_rd_o;
  logic [31:0] mem_addr_o;
  logic [7:0]  mem_len_o;
  logic        mem_accept_i;
  logic        mem_valid_i;
  logic [31:0] mem_data_i;
  logic        mem_error_i;
  logic [10:0] ram_addr_o;
  logic [31:0] ram_data_o;
  logic        ram_wr_o;
`ifdef ICACHE_REFILL_BYPASS_EN
  logic        bypass_valid_o;
  logic [31:0] bypass_data_o;
`endif

  int total = 0;
  int bad   = 0;

  icache_refill_ctrl dut (
    .clk_i          (clk),
    .rst_i          (rst_i),
    .fetch_rd_i     (fetch_rd_i),
    .fetch_addr_i   (fetch_addr_i),
    .fetch_stall_o  (fetch_stall_o),
    .miss_i         (miss_i),
    .miss_pc_i      (miss_pc_i),
    .refill_busy_o  (refill_busy_o),
    .refill_done_o  (refill_done_o),
    .refill_error_o (refill_error_o),
    .mem_rd_o       (mem_rd_o),
    .mem_addr_o     (mem_addr_o),
    .mem_len_o      (mem_len_o),
    .mem_accept_i   (mem_accept_i),
    .mem_valid_i    (mem_valid_i),
    .mem_data_i     (mem_data_i),
    .mem_error_i    (mem_error_i),
    .ram_addr_o     (ram_addr_o),
    .ram_data_o     (ram_data_o),
    .ram_wr_o       (ram_wr_o)
`ifdef ICACHE_REFILL_BYPASS_EN
    ,
    .bypass_valid_o (bypass_valid_o),
    .bypass_data_o  (bypass_data_o)
`endif
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #2000000;
    $display("FAIL watchdog: act=timeout req=finish");
    $fatal(1, "watchdog expired");
  end

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] req);
    total++;
    if (act !== req) begin
      bad++;
      $display("FAIL %s: act=%h req=%h", nm, act, req);
    end
  endtask

  task automatic rand_fetch();
    fetch_rd_i   = 1'($urandom_range(1));
    fetch_addr_i = 11'($urandom);
  endtask

  // Table-driven basic refill: one record per cycle.
  typedef struct {
    logic        miss;
    logic [31:0] pc;
    logic        acc;
    logic        vld;
    logic [31:0] data;
    logic        frd;
    logic [10:0] faddr;
    logic        e_busy;
    logic        e_rd;
    logic        e_wr;
    logic        e_stall;
    logic        e_done;
    logic        e_byp;
    logic [10:0] e_addr;
    logic [31:0] e_data;
    logic [31:0] e_maddr;
    logic [7:0]  e_len;
  } vec_t;

  vec_t tbl[14];

  // One complete refill checked against line arithmetic from the miss PC.
  // hold_next keeps miss_i high in the DONE cycle; the next call's IDLE check
  // then shows it was not taken early.
  task automatic do_refill(input logic [31:0] pc, input int acc_dly, input int gap_pct,
                           input logic [7:0] err_mask, input bit junk, input bit hold_next);
    logic [31:0] exp_maddr;
    logic [10:0] line;
    logic        exp_err;
    logic        v;
    logic [31:0] d;
    int          k;
    int          gaps;
    exp_maddr = pc & ~32'h1F;
    line      = 11'((pc >> 2) & 32'h7F8);
    exp_err   = 1'b0;

    @(negedge clk);
    miss_i = 1'b1; miss_pc_i = pc; mem_accept_i = 1'b0; mem_error_i = 1'b0;
    mem_valid_i = junk; mem_data_i = $urandom;
    rand_fetch();
    #1;
    chk("idle_busy", 32'(refill_busy_o), 0);
    chk("idle_done", 32'(refill_done_o), 0);
    chk("idle_rd", 32'(mem_rd_o), 0);
    chk("idle_wr", 32'(ram_wr_o), 0);
    chk("idle_stall", 32'(fetch_stall_o), 0);
    chk("idle_raddr", 32'(ram_addr_o), 32'(fetch_addr_i));

    for (int i = 0; i <= acc_dly; i++) begin
      @(negedge clk);
      mem_accept_i = (i == acc_dly);
      mem_valid_i  = junk & 1'($urandom_range(1));
      mem_data_i   = $urandom;
      rand_fetch();
      #1;
      chk("req_rd", 32'(mem_rd_o), 1);
      chk("req_busy", 32'(refill_busy_o), 1);
      chk("req_maddr", mem_addr_o, exp_maddr);
      chk("req_len", 32'(mem_len_o), LW - 1);
      chk("req_wr", 32'(ram_wr_o), 0);
      chk("req_stall", 32'(fetch_stall_o), 0);
      chk("req_raddr", 32'(ram_addr_o), 32'(fetch_addr_i));
    end

    k = 0;
    gaps = 0;
    while (k < LW) begin
      @(negedge clk);
      mem_accept_i = 1'b0;
      v = (gaps >= 3) || ($urandom_range(99) >= gap_pct);
      gaps = v ? 0 : gaps + 1;
      d = $urandom;
      mem_valid_i = v;
      mem_data_i  = d;
      mem_error_i = v ? err_mask[k] : 1'($urandom_range(1));
      rand_fetch();
      if (junk) miss_pc_i = $urandom;
      #1;
      chk("fill_rd", 32'(mem_rd_o), 0);
      chk("fill_busy", 32'(refill_busy_o), 1);
      chk("fill_done", 32'(refill_done_o), 0);
      chk("fill_maddr", mem_addr_o, exp_maddr);
      chk("fill_wr", 32'(ram_wr_o), 32'(v));
      chk("fill_stall", 32'(fetch_stall_o), 32'(v & fetch_rd_i));
      chk("fill_raddr", 32'(ram_addr_o), v ? 32'(line + 11'(k)) : 32'(fetch_addr_i));
      if (v) chk("fill_rdata", ram_data_o, d);
`ifdef ICACHE_REFILL_BYPASS_EN
      chk("byp_valid", 32'(bypass_valid_o), 32'(v && (k == int'(pc[4:2]))));
      if (v && (k == int'(pc[4:2]))) chk("byp_data", bypass_data_o, d);
`endif
      if (v) begin
        exp_err = exp_err | err_mask[k];
        k++;
      end
    end

    @(negedge clk);
    mem_valid_i = 1'b0; mem_error_i = 1'b0; miss_i = hold_next;
    rand_fetch();
    #1;
    chk("done_pulse", 32'(refill_done_o), 1);
    chk("done_error", 32'(refill_error_o), 32'(exp_err));
    chk("done_busy", 32'(refill_busy_o), 1);
    chk("done_wr", 32'(ram_wr_o), 0);
    chk("done_raddr", 32'(ram_addr_o), 32'(fetch_addr_i));
  endtask

  initial begin
    vec_t r;

    for (int i = 0; i < 14; i++) begin
      r = '{default: '0};
      r.pc      = 32'h0000_1234;
      r.frd     = 1'b1;
      r.faddr   = 11'h111;
      r.e_addr  = 11'h111;
      r.miss    = (i <= 11);
      r.acc     = (i == 3);
      r.e_busy  = (i >= 1) && (i <= 12);
      r.e_rd    = (i >= 1) && (i <= 3);
      r.e_done  = (i == 12);
      r.e_maddr = (i == 0) ? 32'h0 : 32'h0000_1220;
      r.e_len   = (i == 0) ? 8'd0 : 8'd7;
      // Stray beats in IDLE and REQ must not write.
      if (i <= 1) begin
        r.vld  = 1'b1;
        r.data = 32'hBAD0_0000 + 32'(i);
      end
      if (i >= 4 && i <= 11) begin
        r.vld     = 1'b1;
        r.data    = 32'hD000_0000 + 32'(i - 4);
        r.e_wr    = 1'b1;
        r.e_stall = 1'b1;
        r.e_addr  = 11'h488 + 11'(i - 4);
        r.e_data  = r.data;
        r.e_byp   = ((i - 4) == 5);
      end
      tbl[i] = r;
    end

    rst_i = 1'b0;
    fetch_rd_i = 1'b0; fetch_addr_i = '0; miss_i = 1'b0; miss_pc_i = '0;
    mem_accept_i = 1'b0; mem_valid_i = 1'b0; mem_data_i = '0; mem_error_i = 1'b0;
    #12;
    chk("rst_busy", 32'(refill_busy_o), 0);
    chk("rst_done", 32'(refill_done_o), 0);
    chk("rst_error", 32'(refill_error_o), 0);
    chk("rst_rd", 32'(mem_rd_o), 0);
    chk("rst_maddr", mem_addr_o, 0);
    chk("rst_len", 32'(mem_len_o), 0);
    chk("rst_wr", 32'(ram_wr_o), 0);
    chk("rst_stall", 32'(fetch_stall_o), 0);
    chk("rst_raddr", 32'(ram_addr_o), 0);
    @(negedge clk);
    rst_i = 1'b1;

    for (int i = 0; i < 14; i++) begin
      @(negedge clk);
      miss_i = tbl[i].miss; miss_pc_i = tbl[i].pc; mem_accept_i = tbl[i].acc;
      mem_valid_i = tbl[i].vld; mem_data_i = tbl[i].data; mem_error_i = 1'b0;
      fetch_rd_i = tbl[i].frd; fetch_addr_i = tbl[i].faddr;
      #1;
      chk($sformatf("tbl%0d_busy", i), 32'(refill_busy_o), 32'(tbl[i].e_busy));
      chk($sformatf("tbl%0d_rd", i), 32'(mem_rd_o), 32'(tbl[i].e_rd));
      chk($sformatf("tbl%0d_wr", i), 32'(ram_wr_o), 32'(tbl[i].e_wr));
      chk($sformatf("tbl%0d_stall", i), 32'(fetch_stall_o), 32'(tbl[i].e_stall));
      chk($sformatf("tbl%0d_done", i), 32'(refill_done_o), 32'(tbl[i].e_done));
      chk($sformatf("tbl%0d_err", i), 32'(refill_error_o), 0);
      chk($sformatf("tbl%0d_raddr", i), 32'(ram_addr_o), 32'(tbl[i].e_addr));
      chk($sformatf("tbl%0d_maddr", i), mem_addr_o, tbl[i].e_maddr);
      chk($sformatf("tbl%0d_len", i), 32'(mem_len_o), 32'(tbl[i].e_len));
      if (tbl[i].e_wr) chk($sformatf("tbl%0d_rdata", i), ram_data_o, tbl[i].e_data);
`ifdef ICACHE_REFILL_BYPASS_EN
      chk($sformatf("tbl%0d_byp", i), 32'(bypass_valid_o), 32'(tbl[i].e_byp));
      if (tbl[i].e_byp) chk($sformatf("tbl%0d_bdata", i), bypass_data_o, tbl[i].e_data);
`endif
    end

    // Error on beat 3, then a clean line must report no error.
    do_refill(32'h0000_1234, 0, 0, 8'h08, 1'b0, 1'b0);
    do_refill(32'h0000_2FFC, 1, 0, 8'h00, 1'b0, 1'b0);
    // Gapped beats with fetch traffic.
    do_refill(32'h8000_0040, 2, 50, 8'h00, 1'b0, 1'b0);
    // Stray beats in IDLE/REQ and a new miss PC during FILL.
    do_refill(32'h1234_5678, 3, 30, 8'h80, 1'b1, 1'b0);
    // miss_i held through DONE must wait for the following IDLE cycle.
    do_refill(32'h0000_0100, 0, 20, 8'h01, 1'b0, 1'b1);
    do_refill(32'h0000_0100, 0, 0, 8'h00, 1'b0, 1'b0);

    // Reset after beat 4 of a refill.
    @(negedge clk);
    miss_i = 1'b1; miss_pc_i = 32'h0000_4560; fetch_rd_i = 1'b0; fetch_addr_i = '0;
    @(negedge clk);
    mem_accept_i = 1'b1;
    for (int b = 0; b < 5; b++) begin
      @(negedge clk);
      miss_i = 1'b0; mem_accept_i = 1'b0; mem_valid_i = 1'b1; mem_data_i = 32'(b);
    end
    @(negedge clk);
    mem_valid_i = 1'b0;
    rst_i = 1'b0;
    #1;
    chk("mrst_busy", 32'(refill_busy_o), 0);
    chk("mrst_rd", 32'(mem_rd_o), 0);
    chk("mrst_maddr", mem_addr_o, 0);
    chk("mrst_len", 32'(mem_len_o), 0);
    chk("mrst_done", 32'(refill_done_o), 0);
    chk("mrst_wr", 32'(ram_wr_o), 0);
    chk("mrst_raddr", 32'(ram_addr_o), 0);
    @(negedge clk);
    #1;
    chk("mrst_done2", 32'(refill_done_o), 0);
    @(negedge clk);
    rst_i = 1'b1;
    #1;
    chk("mrst_rel_done", 32'(refill_done_o), 0);
    // Fresh refill must start writing at beat 0.
    do_refill(32'h0000_4560, 0, 0, 8'h00, 1'b0, 1'b0);

    for (int n = 0; n < 30; n++) begin
      do_refill($urandom, $urandom_range(3), $urandom_range(60),
                ($urandom_range(3) == 0) ? 8'($urandom) : 8'h00,
                1'($urandom_range(1)), 1'($urandom_range(1)));
    end

    @(negedge clk);
    miss_i = 1'b0; mem_valid_i = 1'b0; fetch_rd_i = 1'b1; fetch_addr_i = 11'h3A5;
    #1;
    chk("end_done", 32'(refill_done_o), 0);
    chk("end_busy", 32'(refill_busy_o), 0);
    chk("end_raddr", 32'(ram_addr_o), 32'h3A5);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
